// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle controller and its datapath.
// Carries the opcode and memory handshake into the controller, and the
// datapath strobes, mux selects, debug state and retirement counter out.
//   master : controller side (drives strobes, samples op_code/mem_ready)
//   slave  : datapath side (drives op_code/mem_ready, samples strobes)
interface multi_cycle_control_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
);
    logic [OP_W-1:0]    op_code;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               IRWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUop;
    logic [3:0]         state;
    logic               illegal_op;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  op_code, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALUop, state, illegal_op, instr_count
    );

    modport slave (
        output op_code, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALUop, state, illegal_op, instr_count
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle processor control unit: a Moore FSM sequencing fetch, decode,
// memory, execute, write-back, branch, jump and trap steps, plus a saturating
// retired-instruction counter.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : multi_cycle_control_if.master (op_code/mem_ready in, strobes out)
module multi_cycle_control #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_cycle_control_if.master   bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_BGT   = OP_W'(6'b000110);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(6'b000111);
    localparam logic [OP_W-1:0] OP_BLE   = OP_W'(6'b001011);
    localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(6'b000010);

    logic [3:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire_c;

    logic               pc_write, pc_write_cond, i_or_d, ir_write;
    logic               mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b, pc_source;
    logic [ALUOP_W-1:0] alu_op;

    // State, latched opcode and retirement counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; retire_c marks the last cycle of a completed instruction
    always_comb begin
        state_d  = S_FETCH;
        op_d     = op_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = bus.op_code;
                case (bus.op_code)
                    OP_RTYPE:                                 state_d = S_R_EXEC;
                    OP_ADDI, OP_SUBI, OP_ANDI:                state_d = S_I_EXEC;
                    OP_LW, OP_SW:                             state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLE:   state_d = S_BRANCH;
                    OP_JUMP:                                  state_d = S_JUMP;
                    default:                                  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_MEM_WR: begin
                state_d  = bus.mem_ready ? S_FETCH : S_MEM_WR;
                retire_c = bus.mem_ready;
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_TRAP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        cnt_d = (retire_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Moore output decode; only FETCH looks at mem_ready to qualify the IR/PC load
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = '0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // Held off while in reset so no IR/PC load is seen before the first edge
                ir_write  = bus.mem_ready & ~rst;
                pc_write  = bus.mem_ready & ~rst;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(3'b010);
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_SUBI: alu_op = ALUOP_W'(3'b001);
                    OP_ANDI: alu_op = ALUOP_W'(3'b011);
                    default: alu_op = ALUOP_W'(3'b000);
                endcase
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                case (op_q)
                    OP_BEQ:  alu_op = ALUOP_W'(3'b001);
                    OP_BNE:  alu_op = ALUOP_W'(3'b100);
                    OP_BGT:  alu_op = ALUOP_W'(3'b101);
                    OP_BGE:  alu_op = ALUOP_W'(3'b110);
                    OP_BLE:  alu_op = ALUOP_W'(3'b111);
                    default: alu_op = ALUOP_W'(3'b000);
                endcase
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.IRWrite     = ir_write;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.PCSource    = pc_source;
    assign bus.ALUop       = alu_op;
    assign bus.state       = state_q;
    assign bus.illegal_op  = (state_q == S_TRAP);
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multi_cycle_control_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(16)) bus ();
    multi_cycle_control_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(2))  bus2 ();

    multi_cycle_control #(.OP_W(6), .ALUOP_W(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_cycle_control #(.OP_W(6), .ALUOP_W(3), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Strobe order: PCWrite PCWriteCond IorD IRWrite MemRead MemWrite MemtoReg RegDst RegWrite ALUSrcA
    localparam logic [9:0] SB_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] SB_FRDY  = 10'b10_0110_0000;
    localparam logic [9:0] SB_FWAIT = 10'b00_0010_0000;
    localparam logic [9:0] SB_ASA   = 10'b00_0000_0001;
    localparam logic [9:0] SB_MRD   = 10'b00_1010_0000;
    localparam logic [9:0] SB_MWB   = 10'b00_0000_1010;
    localparam logic [9:0] SB_MWR   = 10'b00_1001_0000;
    localparam logic [9:0] SB_RWB   = 10'b00_0000_0110;
    localparam logic [9:0] SB_IWB   = 10'b00_0000_0010;
    localparam logic [9:0] SB_BR    = 10'b01_0000_0001;
    localparam logic [9:0] SB_JMP   = 10'b10_0000_0000;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SUBI = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLE  = 6'b001011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [9:0] sb;
        logic [1:0] srcb;
        logic [1:0] pcs;
        logic [2:0] alu;
        logic       ill;
        int         cnt;
        int         cnt_sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show
    task automatic step(input string tag, input logic r, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [9:0] sb, input logic [1:0] srcb,
                        input logic [1:0] pcs, input logic [2:0] alu, input logic ill,
                        input int cnt, input int cnt_sat);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.op_code    = op;
        bus.mem_ready  = mr;
        bus2.op_code   = op;
        bus2.mem_ready = mr;
        e.tag = tag; e.st = st; e.sb = sb; e.srcb = srcb; e.pcs = pcs;
        e.alu = alu; e.ill = ill; e.cnt = cnt; e.cnt_sat = cnt_sat;
        exp_q.push_back(e);
    endtask

    // Monitor: every falling edge with a pending expectation is one compared vector
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [9:0] sb_a;
            e    = exp_q.pop_front();
            sb_a = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.IRWrite, bus.MemRead,
                    bus.MemWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA};
            n_vec = n_vec + 1;
            if (bus.state !== e.st || sb_a !== e.sb || bus.ALUSrcB !== e.srcb ||
                bus.PCSource !== e.pcs || bus.ALUop !== e.alu || bus.illegal_op !== e.ill ||
                bus.instr_count !== 16'(e.cnt) || bus2.instr_count !== 2'(e.cnt_sat)) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got st=%0d sb=%b srcb=%b pcs=%b alu=%b ill=%b cnt=%0d cnt2=%0d; want st=%0d sb=%b srcb=%b pcs=%b alu=%b ill=%b cnt=%0d cnt2=%0d",
                         e.tag, bus.state, sb_a, bus.ALUSrcB, bus.PCSource, bus.ALUop,
                         bus.illegal_op, bus.instr_count, bus2.instr_count,
                         e.st, e.sb, e.srcb, e.pcs, e.alu, e.ill, e.cnt, e.cnt_sat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_code    = OP_R;
        bus.mem_ready  = 1'b1;
        bus2.op_code   = OP_R;
        bus2.mem_ready = 1'b1;

        // Reset: FETCH decode with IR/PC loads held off even though mem_ready is high
        step("rst_a",     1'b1, OP_R,    1'b1, 4'd0,  SB_FWAIT, 2'b01, 2'b00, 3'b000, 1'b0, 0, 0);
        step("rst_b",     1'b1, OP_R,    1'b1, 4'd0,  SB_FWAIT, 2'b01, 2'b00, 3'b000, 1'b0, 0, 0);

        // R-type: 0,1,6,7,0
        step("r_fetch",   1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 0, 0);
        step("r_decode",  1'b0, OP_R,    1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 0, 0);
        step("r_exec",    1'b0, OP_BAD,  1'b1, 4'd6,  SB_ASA,   2'b00, 2'b00, 3'b010, 1'b0, 0, 0);
        step("r_wb",      1'b0, OP_BAD,  1'b1, 4'd7,  SB_RWB,   2'b00, 2'b00, 3'b000, 1'b0, 0, 0);

        // LW with three wait cycles in MEM_RD; op_code changes after DECODE are ignored
        step("lw_fetch",  1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_decode", 1'b0, OP_LW,   1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_addr",   1'b0, OP_SW,   1'b0, 4'd2,  SB_ASA,   2'b10, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_rd_w1",  1'b0, OP_SW,   1'b0, 4'd3,  SB_MRD,   2'b00, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_rd_w2",  1'b0, OP_SW,   1'b0, 4'd3,  SB_MRD,   2'b00, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_rd_w3",  1'b0, OP_SW,   1'b0, 4'd3,  SB_MRD,   2'b00, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_rd_ok",  1'b0, OP_SW,   1'b1, 4'd3,  SB_MRD,   2'b00, 2'b00, 3'b000, 1'b0, 1, 1);
        step("lw_wb",     1'b0, OP_SW,   1'b1, 4'd4,  SB_MWB,   2'b00, 2'b00, 3'b000, 1'b0, 1, 1);

        // Fetch stall, then BLE
        step("fetch_w",   1'b0, OP_R,    1'b0, 4'd0,  SB_FWAIT, 2'b01, 2'b00, 3'b000, 1'b0, 2, 2);
        step("ble_fetch", 1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 2, 2);
        step("ble_dec",   1'b0, OP_BLE,  1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 2, 2);
        step("ble_br",    1'b0, OP_R,    1'b1, 4'd10, SB_BR,    2'b00, 2'b01, 3'b111, 1'b0, 2, 2);

        // SUBI
        step("subi_fet",  1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 3, 3);
        step("subi_dec",  1'b0, OP_SUBI, 1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 3, 3);
        step("subi_ex",   1'b0, OP_R,    1'b1, 4'd8,  SB_ASA,   2'b10, 2'b00, 3'b001, 1'b0, 3, 3);
        step("subi_wb",   1'b0, OP_R,    1'b1, 4'd9,  SB_IWB,   2'b00, 2'b00, 3'b000, 1'b0, 3, 3);

        // Illegal opcode: one TRAP cycle, counter unchanged
        step("bad_fet",   1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 4, 3);
        step("bad_dec",   1'b0, OP_BAD,  1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 4, 3);
        step("bad_trap",  1'b0, OP_R,    1'b1, 4'd12, SB_NONE,  2'b00, 2'b00, 3'b000, 1'b1, 4, 3);

        // Jump
        step("j_fet",     1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 4, 3);
        step("j_dec",     1'b0, OP_J,    1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 4, 3);
        step("j_jump",    1'b0, OP_R,    1'b1, 4'd11, SB_JMP,   2'b00, 2'b10, 3'b000, 1'b0, 4, 3);

        // BNE
        step("bne_fet",   1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 5, 3);
        step("bne_dec",   1'b0, OP_BNE,  1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 5, 3);
        step("bne_br",    1'b0, OP_R,    1'b1, 4'd10, SB_BR,    2'b00, 2'b01, 3'b100, 1'b0, 5, 3);

        // ANDI
        step("andi_fet",  1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 6, 3);
        step("andi_dec",  1'b0, OP_ANDI, 1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 6, 3);
        step("andi_ex",   1'b0, OP_R,    1'b1, 4'd8,  SB_ASA,   2'b10, 2'b00, 3'b011, 1'b0, 6, 3);
        step("andi_wb",   1'b0, OP_R,    1'b1, 4'd9,  SB_IWB,   2'b00, 2'b00, 3'b000, 1'b0, 6, 3);

        // SW stalled in MEM_WR, then reset mid-write; mem_ready low in DECODE/MEM_ADDR is ignored
        step("sw_fet",    1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 7, 3);
        step("sw_dec",    1'b0, OP_SW,   1'b0, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 7, 3);
        step("sw_addr",   1'b0, OP_SW,   1'b0, 4'd2,  SB_ASA,   2'b10, 2'b00, 3'b000, 1'b0, 7, 3);
        step("sw_wr_w1",  1'b0, OP_SW,   1'b0, 4'd5,  SB_MWR,   2'b00, 2'b00, 3'b000, 1'b0, 7, 3);
        step("sw_wr_w2",  1'b0, OP_SW,   1'b0, 4'd5,  SB_MWR,   2'b00, 2'b00, 3'b000, 1'b0, 7, 3);
        step("sw_rst_a",  1'b1, OP_SW,   1'b0, 4'd0,  SB_FWAIT, 2'b01, 2'b00, 3'b000, 1'b0, 0, 0);
        step("sw_rst_b",  1'b1, OP_SW,   1'b1, 4'd0,  SB_FWAIT, 2'b01, 2'b00, 3'b000, 1'b0, 0, 0);

        // SW completing with mem_ready high: 4 cycles, retires
        step("sw2_fet",   1'b0, OP_R,    1'b1, 4'd0,  SB_FRDY,  2'b01, 2'b00, 3'b000, 1'b0, 0, 0);
        step("sw2_dec",   1'b0, OP_SW,   1'b1, 4'd1,  SB_NONE,  2'b11, 2'b00, 3'b000, 1'b0, 0, 0);
        step("sw2_addr",  1'b0, OP_R,    1'b1, 4'd2,  SB_ASA,   2'b10, 2'b00, 3'b000, 1'b0, 0, 0);
        step("sw2_wr",    1'b0, OP_R,    1'b1, 4'd5,  SB_MWR,   2'b00, 2'b00, 3'b000, 1'b0, 0, 0);
        step("sw2_done",  1'b0, OP_R,    1'b0, 4'd0,  SB_FWAIT, 2'b01, 2'b00, 3'b000, 1'b0, 1, 1);

        // Drain: bounded wait for the monitor to consume every queued expectation
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_vec = n_vec + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
